// File: rtl/virtio_notify_ctrl.sv
// Virtio queue-notify controller: snoops CSR writes, coalesces per-queue notifies,
// arbitrates them round-robin to a valid/ready stream, and tracks ISR/status/irq.
module virtio_notify_ctrl #(
    parameter int          NUM_Q       = 3,
    parameter logic [31:0] NOTIFY_ADDR = 32'h10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic        notify_valid,
    output logic [1:0]  notify_qid,
    input  logic        notify_ready,
    input  logic        cmpl_valid,
    output logic [7:0]  isr,
    output logic        irq,
    output logic [7:0]  dev_status,
    output logic        dev_reset,
    output logic [15:0] notify_cnt
);

    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [1:0] LAST_Q = 2'(NUM_Q - 1);

    state_t      state;
    logic [3:0]  pending;
    logic [3:0]  pending_set;
    logic [3:0]  pending_clr;
    logic [1:0]  last_granted;
    logic [1:0]  next_qid;
    logic        hit;
    logic        notify_wr;
    logic        status_wr;
    logic        dev_rst_wr;
    logic        isr_rd;
    logic        xfer;
    logic        isr_bit;
    logic        unused_din;

    assign hit        = en && (addr == NOTIFY_ADDR);
    assign status_wr  = hit && we[2];
    assign dev_rst_wr = status_wr && (din[23:16] == 8'h00);
    // A notify that lands together with a device reset is dropped.
    assign notify_wr  = hit && (we[1:0] == 2'b11) && (din[15:0] < 16'(NUM_Q)) && !dev_rst_wr;
    assign isr_rd     = hit && (we == 4'b0000);
    assign xfer       = (state == OFFER) && notify_ready;
    assign isr        = {7'b0000000, isr_bit};
    assign unused_din = ^din[31:24];

    always_comb begin
        pending_set = 4'b0000;
        pending_clr = 4'b0000;
        if (notify_wr) pending_set[din[1:0]] = 1'b1;
        if (xfer)      pending_clr[notify_qid] = 1'b1;
    end

    // Scan downward so the last hit kept is the nearest queue after last_granted.
    always_comb begin
        logic [1:0] idx;
        idx      = 2'd0;
        next_qid = 2'd0;
        for (int k = NUM_Q; k >= 1; k--) begin
            idx = 2'((int'(last_granted) + k) % NUM_Q);
            if (pending[idx]) next_qid = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            notify_valid <= 1'b0;
            notify_qid   <= 2'd0;
            pending      <= 4'b0000;
            last_granted <= LAST_Q;
            notify_cnt   <= 16'd0;
        end else begin
            if (xfer) notify_cnt <= notify_cnt + 16'd1;
            if (dev_rst_wr) begin
                state        <= IDLE;
                notify_valid <= 1'b0;
                pending      <= 4'b0000;
                last_granted <= LAST_Q;
            end else begin
                // Set is applied after clear so a same-cycle re-notify survives.
                pending <= (pending & ~pending_clr) | pending_set;
                case (state)
                    IDLE: begin
                        if (|pending) begin
                            state        <= OFFER;
                            notify_valid <= 1'b1;
                            notify_qid   <= next_qid;
                        end
                    end
                    OFFER: begin
                        if (notify_ready) begin
                            state        <= IDLE;
                            notify_valid <= 1'b0;
                            last_granted <= notify_qid;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        notify_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isr_bit    <= 1'b0;
            irq        <= 1'b0;
            dev_status <= 8'h00;
            dev_reset  <= 1'b0;
        end else begin
            dev_reset <= dev_rst_wr;
            if (status_wr) dev_status <= din[23:16];
            if (dev_rst_wr)      isr_bit <= 1'b0;
            else if (cmpl_valid) isr_bit <= 1'b1;
            else if (isr_rd)     isr_bit <= 1'b0;
            irq <= isr_bit & dev_status[2];
        end
    end

endmodule

// File: tb/tb_virtio_notify_ctrl.sv
// Scoreboard bench for virtio_notify_ctrl: directed CSR writes push expected queue
// ids, a negedge monitor pops them on every downstream transfer.
module tb_virtio_notify_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic        notify_valid;
    logic [1:0]  notify_qid;
    logic        notify_ready;
    logic        cmpl_valid;
    logic [7:0]  isr;
    logic        irq;
    logic [7:0]  dev_status;
    logic        dev_reset;
    logic [15:0] notify_cnt;

    int compared   = 0;
    int mismatched = 0;
    int exp_q[$];

    logic       prev_xfer;
    logic       prev_valid;
    logic [1:0] prev_qid;

    virtio_notify_ctrl #(.NUM_Q(3), .NOTIFY_ADDR(32'h10)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .we           (we),
        .addr         (addr),
        .din          (din),
        .notify_valid (notify_valid),
        .notify_qid   (notify_qid),
        .notify_ready (notify_ready),
        .cmpl_valid   (cmpl_valid),
        .isr          (isr),
        .irq          (irq),
        .dev_status   (dev_status),
        .dev_reset    (dev_reset),
        .notify_cnt   (notify_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // One CSR access sampled at a single rising edge; exp_qid >= 0 queues an expected transfer.
    task automatic applyStimulus(input logic e, input logic [3:0] w, input logic [31:0] a,
                                 input logic [31:0] d, input logic c, input int exp_qid);
        @(posedge clk);
        #1;
        en = e; we = w; addr = a; din = d; cmpl_valid = c;
        if (exp_qid >= 0) exp_q.push_back(exp_qid);
        @(posedge clk);
        #1;
        en = 1'b0; we = 4'b0000; addr = 32'h0; din = 32'h0; cmpl_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        notify_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"},      notify_valid, 0);
        checkOutput({tag, "_qid"},        notify_qid, 0);
        checkOutput({tag, "_isr"},        isr, 0);
        checkOutput({tag, "_irq"},        irq, 0);
        checkOutput({tag, "_dev_status"}, dev_status, 0);
        checkOutput({tag, "_dev_reset"},  dev_reset, 0);
        checkOutput({tag, "_cnt"},        notify_cnt, 0);
    endtask

    task automatic drainWait(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_drain: %0d transfers still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: checks every transfer against the scoreboard plus offer stability and gaps.
    always @(negedge clk) begin
        if (rst) begin
            prev_xfer  = 1'b0;
            prev_valid = 1'b0;
            prev_qid   = 2'd0;
        end else begin
            if (prev_xfer)
                checkOutput("gap_after_xfer", notify_valid, 0);
            else if (prev_valid && notify_valid)
                checkOutput("qid_stable", notify_qid, prev_qid);
            if (notify_valid && notify_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_xfer: got qid %0d, required no transfer", notify_qid);
                end else begin
                    checkOutput("xfer_qid", notify_qid, exp_q.pop_front());
                end
            end
            prev_xfer  = notify_valid && notify_ready;
            prev_valid = notify_valid;
            prev_qid   = notify_qid;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; we = 4'b0000; addr = 32'h0; din = 32'h0;
        notify_ready = 1'b0; cmpl_valid = 1'b0;

        // Reset values while rst is held.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single notify: offer appears two edges after the write.
        notify_ready = 1'b1;
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0001, 1'b0, 1);
        @(negedge clk);
        checkOutput("latency_early_valid", notify_valid, 0);
        @(negedge clk);
        checkOutput("latency_valid", notify_valid, 1);
        checkOutput("latency_qid", notify_qid, 1);
        drainWait("single");
        checkOutput("single_cnt", notify_cnt, 1);

        // Re-notify in the transfer cycle keeps the queue pending: two transfers.
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0001, 1'b0, 1);
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0001, 1'b0, 1);
        drainWait("set_wins");
        checkOutput("set_wins_cnt", notify_cnt, 3);

        // Out-of-range queue index is ignored.
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0003, 1'b0, -1);
        repeat (4) @(negedge clk);
        checkOutput("oob_valid", notify_valid, 0);
        checkOutput("oob_cnt", notify_cnt, 3);

        // Writes 2,0,1 with ready low: queue 2 is offered before the others land,
        // then round-robin from 2 gives 0 then 1.
        doReset();
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0002, 1'b0, 2);
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0000, 1'b0, 0);
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0001, 1'b0, 1);
        repeat (3) @(negedge clk);
        checkOutput("rr_hold_valid", notify_valid, 1);
        checkOutput("rr_hold_qid", notify_qid, 2);
        notify_ready = 1'b1;
        drainWait("rr");
        checkOutput("rr_cnt", notify_cnt, 3);

        // Coalescing: three notifies to a pending queue give one transfer.
        doReset();
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0000, 1'b0, 0);
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0000, 1'b0, -1);
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0000, 1'b0, -1);
        @(negedge clk);
        notify_ready = 1'b1;
        drainWait("coalesce");
        repeat (4) @(negedge clk);
        checkOutput("coalesce_cnt", notify_cnt, 1);
        checkOutput("coalesce_valid", notify_valid, 0);

        // ISR set, irq lag, read-to-clear, and set-wins over read.
        doReset();
        applyStimulus(1'b1, 4'b0100, 32'h10, 32'h0004_0000, 1'b0, -1);
        @(negedge clk);
        checkOutput("status_load", dev_status, 8'h04);
        applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, -1);
        @(negedge clk);
        checkOutput("isr_set", isr, 8'h01);
        checkOutput("irq_lag", irq, 0);
        @(negedge clk);
        checkOutput("irq_set", irq, 1);
        applyStimulus(1'b1, 4'b0000, 32'h14, 32'h0, 1'b0, -1);
        @(negedge clk);
        checkOutput("isr_other_read", isr, 8'h01);
        applyStimulus(1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, -1);
        @(negedge clk);
        checkOutput("isr_clear", isr, 8'h00);
        @(negedge clk);
        checkOutput("irq_clear", irq, 0);
        applyStimulus(1'b1, 4'b0000, 32'h10, 32'h0, 1'b1, -1);
        repeat (2) @(negedge clk);
        checkOutput("isr_set_wins", isr, 8'h01);
        checkOutput("irq_set_wins", irq, 1);

        // Device reset mid-offer with a second queue pending.
        doReset();
        applyStimulus(1'b1, 4'b0100, 32'h10, 32'h0004_0000, 1'b0, -1);
        applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, -1);
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0001, 1'b0, -1);
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0002, 1'b0, -1);
        @(negedge clk);
        checkOutput("devrst_pre_valid", notify_valid, 1);
        checkOutput("devrst_pre_qid", notify_qid, 1);
        applyStimulus(1'b1, 4'b0100, 32'h10, 32'h0000_0000, 1'b0, -1);
        @(negedge clk);
        checkOutput("devrst_valid", notify_valid, 0);
        checkOutput("devrst_pulse", dev_reset, 1);
        checkOutput("devrst_status", dev_status, 8'h00);
        checkOutput("devrst_isr", isr, 8'h00);
        @(negedge clk);
        checkOutput("devrst_pulse_end", dev_reset, 0);
        notify_ready = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("devrst_no_offer", notify_valid, 0);
        checkOutput("devrst_cnt", notify_cnt, 0);

        // Notify combined with a device-reset status write is discarded.
        applyStimulus(1'b1, 4'b0111, 32'h10, 32'h0000_0001, 1'b0, -1);
        @(negedge clk);
        checkOutput("combo_pulse", dev_reset, 1);
        repeat (4) @(negedge clk);
        checkOutput("combo_no_offer", notify_valid, 0);

        // Asynchronous reset mid-offer.
        notify_ready = 1'b0;
        applyStimulus(1'b1, 4'b0100, 32'h10, 32'h0004_0000, 1'b0, -1);
        applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, -1);
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0002, 1'b0, -1);
        repeat (2) @(negedge clk);
        checkOutput("async_pre_valid", notify_valid, 1);
        checkOutput("async_pre_qid", notify_qid, 2);
        checkOutput("async_pre_irq", irq, 1);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("async");
        @(negedge clk);
        rst = 1'b0;
        notify_ready = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("async_no_offer", notify_valid, 0);
        applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0000_0001, 1'b0, 1);
        drainWait("async_after");
        checkOutput("async_after_cnt", notify_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
